// File: rtl/store_commit_buffer.sv
// store_commit_buffer: in-order store FIFO; ROB commits entries, committed head drains to the dbus arbiter
package store_commit_buffer_pkg;
    typedef struct packed {
        logic [31:0] paddr;
        logic [31:0] wrdata;
        logic [3:0]  byteenable;
        logic        uncached;
        logic        write;
    } data_memreq_t;
endpackage

module store_commit_buffer
    import store_commit_buffer_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH) + 1,
    localparam int IDX_W = PTR_W - 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  data_memreq_t push_req,
    output logic         push_ready,
    input  logic [1:0]   commit_cnt,
    input  logic         flush,
    output data_memreq_t store_dbus,
    output logic         store_dbus_req,
    input  logic         store_dbus_ready,
    input  logic [31:0]  ld_paddr,
    output logic         ld_conflict,
    output logic         empty,
    output logic         full
);
    data_memreq_t entry [DEPTH];
    logic [PTR_W-1:0] head, cmt, tail, count, pending, cmt_inc, cmt_nxt;
    logic [DEPTH-1:0] hit;
    logic pop, do_push, unused_ok;

    assign count          = tail - head;
    assign pending        = tail - cmt;
    assign cmt_inc        = PTR_W'(commit_cnt) > pending ? pending : PTR_W'(commit_cnt);
    assign cmt_nxt        = cmt + cmt_inc;
    assign full           = (tail ^ head) == {1'b1, {IDX_W{1'b0}}};
    assign empty          = tail == head;
    assign push_ready     = !full;
    assign store_dbus_req = head != cmt;
    assign store_dbus     = store_dbus_req ? entry[head[IDX_W-1:0]] : '0;
    assign pop            = store_dbus_req && store_dbus_ready;
    assign do_push        = push && push_ready && !flush;
    assign unused_ok      = ^ld_paddr[1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head <= '0;
            cmt  <= '0;
            tail <= '0;
        end else begin
            head <= head + PTR_W'(pop);
            cmt  <= cmt_nxt;
            tail <= flush ? cmt_nxt : tail + PTR_W'(do_push);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && do_push)
            entry[tail[IDX_W-1:0]] <= push_req;
    end

    always_ff @(posedge clk) begin
        if (rst_n)
            assert (PTR_W'(commit_cnt) <= pending) else $error("commit_cnt exceeds uncommitted entries");
    end

    // Slot i is valid when its distance from head is below the occupancy.
    for (genvar i = 0; i < DEPTH; i++) begin : g_hit
        logic [IDX_W-1:0] off;
        assign off    = IDX_W'(i) - head[IDX_W-1:0];
        assign hit[i] = ({1'b0, off} < count) && (entry[i].paddr[31:2] == ld_paddr[31:2]);
    end
    assign ld_conflict = |hit;
endmodule
